// File: rtl/find_table_mc.sv
// find_table_mc: lowest free row finder per size class with a reservation mask.
// Ports: alloc_* request in / result out (valid/ready), alloc_fail_* reject pulse, upd_* row update.
module find_table_mc #(
  parameter int ROWS = 64,
  parameter int CLASSES = 4,
  parameter int ID_W = 8,
  parameter int OSZ_W = 2,
  parameter int FAIL_FAST = 0,
  localparam int IDX_W = $clog2(ROWS),
  localparam int CLS_W = $clog2(CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid_in,
  output logic             alloc_ready_out,
  input  logic [ID_W-1:0]  alloc_id_in,
  input  logic [CLS_W-1:0] alloc_size_in,
  input  logic [OSZ_W-1:0] alloc_origin_size_in,
  output logic             alloc_valid_out,
  input  logic             alloc_ready_in,
  output logic [ID_W-1:0]  alloc_id_out,
  output logic [IDX_W-1:0] alloc_row_index_out,
  output logic [CLS_W-1:0] alloc_size_out,
  output logic [OSZ_W-1:0] alloc_origin_size_out,
  output logic             alloc_fail_out,
  output logic [ID_W-1:0]  alloc_fail_id_out,
  input  logic             upd_valid_in,
  input  logic [IDX_W-1:0] upd_idx_in,
  input  logic [CLASSES-1:0] upd_bits_in
);

  logic [ROWS-1:0]  tbl_q [CLASSES];
  logic [ROWS-1:0]  tbl_d [CLASSES];
  logic [ROWS-1:0]  mask_q, mask_d;

  logic             s1_vld_q, s1_vld_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic [CLS_W-1:0] s1_size_q, s1_size_d;
  logic [OSZ_W-1:0] s1_osz_q, s1_osz_d;

  logic             o_vld_q, o_vld_d;
  logic [ID_W-1:0]  o_id_q, o_id_d;
  logic [IDX_W-1:0] o_row_q, o_row_d;
  logic [CLS_W-1:0] o_size_q, o_size_d;
  logic [OSZ_W-1:0] o_osz_q, o_osz_d;

  logic             fail_q, fail_d;
  logic [ID_W-1:0]  fail_id_q, fail_id_d;

  logic [ROWS-1:0]  v;
  logic             found;
  logic [IDX_W-1:0] row;
  logic             issue, drop, accept;

  // Downward scan so the last hit written is the lowest free row.
  always_comb begin
    v = tbl_q[s1_size_q] | mask_q;
    found = ~&v;
    row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!v[i]) row = i[IDX_W-1:0];
    end
  end

  assign issue = s1_vld_q & found & (~o_vld_q | alloc_ready_in);
  assign drop = s1_vld_q & ~found & (FAIL_FAST != 0);
  assign alloc_ready_out = ~s1_vld_q | issue | drop;
  assign accept = alloc_valid_in & alloc_ready_out;

  always_comb begin
    tbl_d = tbl_q;
    mask_d = mask_q;
    if (upd_valid_in) begin
      for (int c = 0; c < CLASSES; c++) begin
        tbl_d[c][upd_idx_in] = upd_bits_in[c];
      end
      mask_d[upd_idx_in] = 1'b0;
    end
    // Applied after the update so a same-row reservation survives.
    if (issue) mask_d[row] = 1'b1;

    s1_vld_d = s1_vld_q;
    s1_id_d = s1_id_q;
    s1_size_d = s1_size_q;
    s1_osz_d = s1_osz_q;
    if (issue || drop) s1_vld_d = 1'b0;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_id_d = alloc_id_in;
      s1_size_d = alloc_size_in;
      s1_osz_d = alloc_origin_size_in;
    end

    o_vld_d = o_vld_q;
    o_id_d = o_id_q;
    o_row_d = o_row_q;
    o_size_d = o_size_q;
    o_osz_d = o_osz_q;
    if (o_vld_q && alloc_ready_in) o_vld_d = 1'b0;
    if (issue) begin
      o_vld_d = 1'b1;
      o_id_d = s1_id_q;
      o_row_d = row;
      o_size_d = s1_size_q;
      o_osz_d = s1_osz_q;
    end

    fail_d = drop;
    fail_id_d = drop ? s1_id_q : fail_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CLASSES; c++) begin
        tbl_q[c] <= '0;
      end
      mask_q <= '0;
      s1_vld_q <= 1'b0;
      s1_id_q <= '0;
      s1_size_q <= '0;
      s1_osz_q <= '0;
      o_vld_q <= 1'b0;
      o_id_q <= '0;
      o_row_q <= '0;
      o_size_q <= '0;
      o_osz_q <= '0;
      fail_q <= 1'b0;
      fail_id_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      mask_q <= mask_d;
      s1_vld_q <= s1_vld_d;
      s1_id_q <= s1_id_d;
      s1_size_q <= s1_size_d;
      s1_osz_q <= s1_osz_d;
      o_vld_q <= o_vld_d;
      o_id_q <= o_id_d;
      o_row_q <= o_row_d;
      o_size_q <= o_size_d;
      o_osz_q <= o_osz_d;
      fail_q <= fail_d;
      fail_id_q <= fail_id_d;
    end
  end

  assign alloc_valid_out = o_vld_q;
  assign alloc_id_out = o_id_q;
  assign alloc_row_index_out = o_row_q;
  assign alloc_size_out = o_size_q;
  assign alloc_origin_size_out = o_osz_q;
  assign alloc_fail_out = fail_q;
  assign alloc_fail_id_out = fail_id_q;

endmodule

// File: tb/tb_find_table_mc.sv
// tb_find_table_mc: directed bench with scoreboard for find_table_mc.
// Instance a: 64 rows, stall mode. Instance b: 8 rows, fail-fast mode.
module tb_find_table_mc;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] row;
    logic [1:0] sz;
    logic [1:0] osz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_vi, a_ro, a_vo, a_ri, a_fail, a_uv;
  logic [7:0] a_id, a_ido, a_fido;
  logic [1:0] a_sz, a_szo, a_osz, a_oszo;
  logic [5:0] a_row, a_uidx;
  logic [3:0] a_ubits;

  logic       b_vi, b_ro, b_vo, b_ri, b_fail, b_uv;
  logic [7:0] b_id, b_ido, b_fido;
  logic [1:0] b_sz, b_szo, b_osz, b_oszo;
  logic [2:0] b_row, b_uidx;
  logic [3:0] b_ubits;

  int checks = 0;
  int errors = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  find_table_mc #(
    .ROWS(64), .CLASSES(4), .ID_W(8), .OSZ_W(2), .FAIL_FAST(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .alloc_valid_in(a_vi), .alloc_ready_out(a_ro),
    .alloc_id_in(a_id), .alloc_size_in(a_sz),
    .alloc_origin_size_in(a_osz),
    .alloc_valid_out(a_vo), .alloc_ready_in(a_ri),
    .alloc_id_out(a_ido), .alloc_row_index_out(a_row),
    .alloc_size_out(a_szo), .alloc_origin_size_out(a_oszo),
    .alloc_fail_out(a_fail), .alloc_fail_id_out(a_fido),
    .upd_valid_in(a_uv), .upd_idx_in(a_uidx), .upd_bits_in(a_ubits)
  );

  find_table_mc #(
    .ROWS(8), .CLASSES(4), .ID_W(8), .OSZ_W(2), .FAIL_FAST(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .alloc_valid_in(b_vi), .alloc_ready_out(b_ro),
    .alloc_id_in(b_id), .alloc_size_in(b_sz),
    .alloc_origin_size_in(b_osz),
    .alloc_valid_out(b_vo), .alloc_ready_in(b_ri),
    .alloc_id_out(b_ido), .alloc_row_index_out(b_row),
    .alloc_size_out(b_szo), .alloc_origin_size_out(b_oszo),
    .alloc_fail_out(b_fail), .alloc_fail_id_out(b_fido),
    .upd_valid_in(b_uv), .upd_idx_in(b_uidx), .upd_bits_in(b_ubits)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int id, input int row, input int sz,
                        input int osz);
    exp_t e;
    e.id = id[7:0];
    e.row = row[7:0];
    e.sz = sz[1:0];
    e.osz = osz[1:0];
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int id, input int row, input int sz,
                        input int osz);
    exp_t e;
    e.id = id[7:0];
    e.row = row[7:0];
    e.sz = sz[1:0];
    e.osz = osz[1:0];
    sb_b.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && a_vo && a_ri) begin
      if (sb_a.size() == 0) chk("a_extra_out", a_vo, 0);
      else begin
        e = sb_a.pop_front();
        chk("a_id", a_ido, e.id);
        chk("a_row", a_row, e.row);
        chk("a_size", a_szo, e.sz);
        chk("a_osz", a_oszo, e.osz);
      end
    end
    if (!rst && b_vo && b_ri) begin
      if (sb_b.size() == 0) chk("b_extra_out", b_vo, 0);
      else begin
        e = sb_b.pop_front();
        chk("b_id", b_ido, e.id);
        chk("b_row", b_row, e.row);
        chk("b_size", b_szo, e.sz);
        chk("b_osz", b_oszo, e.osz);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_vi = 1'b0; a_id = 8'd0; a_sz = 2'd0; a_osz = 2'd0; a_ri = 1'b1;
    a_uv = 1'b0; a_uidx = 6'd0; a_ubits = 4'd0;
    b_vi = 1'b0; b_id = 8'd0; b_sz = 2'd0; b_osz = 2'd0; b_ri = 1'b1;
    b_uv = 1'b0; b_uidx = 3'd0; b_ubits = 4'd0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_rdy", a_ro, 1);
    chk("rst_a_vo", a_vo, 0);
    chk("rst_a_fail", a_fail, 0);
    chk("rst_b_rdy", b_ro, 1);
    chk("rst_b_vo", b_vo, 0);
    chk("rst_b_fail", b_fail, 0);
    tick();

    // 64 class-0 requests fill rows 0..63 in order
    for (int i = 0; i < 64; i++) begin
      a_vi = 1'b1; a_id = i[7:0]; a_sz = 2'd0; a_osz = i[1:0];
      push_a(i, i, 0, i & 3);
      @(negedge clk);
      chk("fill_rdy", a_ro, 1);
      if (i == 1) chk("lat_edge_n", a_vo, 0);
      if (i == 2) chk("lat_edge_n1", a_vo, 1);
      tick();
    end
    a_vi = 1'b0;
    repeat (3) tick();
    chk("fill_sb_empty", sb_a.size(), 0);

    // all rows reserved: id 99 stalls until row 5 is updated
    a_vi = 1'b1; a_id = 8'd99; a_sz = 2'd0; a_osz = 2'd3;
    push_a(99, 5, 0, 3);
    @(negedge clk);
    chk("full_acc_rdy", a_ro, 1);
    tick();
    a_vi = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall_rdy", a_ro, 0);
      chk("full_stall_vo", a_vo, 0);
      tick();
    end
    a_uv = 1'b1; a_uidx = 6'd5; a_ubits = 4'b0000;
    tick();
    a_uv = 1'b0;
    @(negedge clk);
    chk("upd5_vo_n", a_vo, 0);
    tick();
    @(negedge clk);
    chk("upd5_vo_n1", a_vo, 1);
    chk("upd5_row", a_row, 5);
    tick();
    repeat (2) tick();

    // class 2 full except row 40; updates also clear the mask
    for (int r = 0; r < 64; r++) begin
      a_uv = 1'b1; a_uidx = r[5:0];
      a_ubits = (r == 40) ? 4'b0000 : 4'b0100;
      tick();
    end
    a_uv = 1'b0;
    a_vi = 1'b1; a_id = 8'd10; a_sz = 2'd2; a_osz = 2'd1;
    push_a(10, 40, 2, 1);
    tick();
    a_id = 8'd11; a_osz = 2'd2;
    push_a(11, 40, 2, 2);
    @(negedge clk);
    chk("c2_second_rdy", a_ro, 1);
    tick();
    a_vi = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("c2_stall_rdy", a_ro, 0);
    chk("c2_stall_vo", a_vo, 0);
    chk("c2_first_done", sb_a.size(), 1);
    tick();
    a_uv = 1'b1; a_uidx = 6'd40; a_ubits = 4'b0000;
    tick();
    a_uv = 1'b0;
    @(negedge clk);
    chk("c2_upd_vo_n", a_vo, 0);
    tick();
    @(negedge clk);
    chk("c2_upd_vo_n1", a_vo, 1);
    tick();
    repeat (2) tick();

    // backpressure: clear row 40, three class-0 requests, ready low
    a_uv = 1'b1; a_uidx = 6'd40; a_ubits = 4'b0000;
    tick();
    a_uv = 1'b0;
    a_ri = 1'b0;
    a_vi = 1'b1; a_sz = 2'd0; a_id = 8'd20; a_osz = 2'd0;
    push_a(20, 0, 0, 0);
    tick();
    a_id = 8'd21; a_osz = 2'd1;
    push_a(21, 1, 0, 1);
    tick();
    a_id = 8'd22; a_osz = 2'd2;
    push_a(22, 2, 0, 2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rdy", a_ro, 0);
      chk("bp_vo", a_vo, 1);
      chk("bp_id_stable", a_ido, 20);
      chk("bp_row_stable", a_row, 0);
      tick();
    end
    a_ri = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", a_ro, 1);
    tick();
    a_vi = 1'b0;
    @(negedge clk);
    chk("bp_gap1_vo", a_vo, 1);
    chk("bp_gap1_id", a_ido, 21);
    tick();
    @(negedge clk);
    chk("bp_gap2_vo", a_vo, 1);
    chk("bp_gap2_id", a_ido, 22);
    tick();
    @(negedge clk);
    chk("bp_done_vo", a_vo, 0);
    tick();

    // reservation and update hit row 3 on the same edge
    a_vi = 1'b1; a_id = 8'd30; a_osz = 2'd3;
    push_a(30, 3, 0, 3);
    tick();
    a_vi = 1'b0;
    a_uv = 1'b1; a_uidx = 6'd3; a_ubits = 4'b0000;
    tick();
    a_uv = 1'b0;
    a_vi = 1'b1; a_id = 8'd31; a_osz = 2'd0;
    push_a(31, 4, 0, 0);
    tick();
    a_vi = 1'b0;
    repeat (4) tick();
    chk("same_row_sb_empty", sb_a.size(), 0);
    chk("a_never_fails", a_fail, 0);

    // fail-fast instance: fill 8 rows, then two rejected requests
    for (int i = 0; i < 8; i++) begin
      b_vi = 1'b1; b_id = 8'(100 + i); b_sz = 2'd0; b_osz = 2'd1;
      push_b(100 + i, i, 0, 1);
      tick();
    end
    b_vi = 1'b0;
    repeat (3) tick();
    chk("ff_fill_sb_empty", sb_b.size(), 0);
    b_vi = 1'b1; b_id = 8'd7;
    tick();
    b_vi = 1'b0;
    @(negedge clk);
    chk("ff_no_fail_yet", b_fail, 0);
    tick();
    b_vi = 1'b1; b_id = 8'd8;
    @(negedge clk);
    chk("ff_fail", b_fail, 1);
    chk("ff_fail_id", b_fido, 7);
    chk("ff_fail_vo", b_vo, 0);
    chk("ff_fail_rdy", b_ro, 1);
    tick();
    b_vi = 1'b0;
    @(negedge clk);
    chk("ff_pulse_end", b_fail, 0);
    tick();
    @(negedge clk);
    chk("ff_fail2", b_fail, 1);
    chk("ff_fail2_id", b_fido, 8);
    tick();
    @(negedge clk);
    chk("ff_fail2_end", b_fail, 0);
    chk("ff_final_vo", b_vo, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
